// File: rtl/serial_mux_dff_shift.sv
// serial_mux_dff_shift: serial-in, parallel-out shift register.
//
// The register is a chain of per-bit cells. Each cell is a 2:1 mux feeding a
// D flip-flop. The entry cell's mux passes the serial input D_in. Every other
// cell's mux passes its upstream neighbour's flop. The mux selects are fixed
// at elaboration by SHIFT_LEFT, so there is no runtime select.
//
// State advances on every rising edge of push; there is no enable.
// reset is asynchronous and active-low. It loads RESET_VAL into the chain.
//
// Optional build macro MUX_DFF_FILL_CNT_EN adds two outputs:
//   fill_cnt - a saturating count of pushes since reset.
//   full     - asserted once every stage holds post-reset serial data.
// Without the macro, the port list is exactly push, reset, D_in, D_out.

// One stage: mux (serial input vs. neighbour) into an async-reset DFF.
module serial_mux_dff_cell #(
  parameter bit   IS_ENTRY = 1'b0,
  parameter logic RST_BIT  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ser_i,
  input  logic nbr_i,
  output logic q_o
);

  logic q_d;
  logic q_q;

  // Stage mux: the select is a constant, so this reduces to a wire after elaboration.
  always_comb begin
    q_d = nbr_i;
    if (IS_ENTRY) q_d = ser_i;
  end

  // Stage flop: async clear to this bit's reset value, capture mux on push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= RST_BIT;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

module serial_mux_dff_shift #(
  parameter int               WIDTH      = 8,
  parameter bit               SHIFT_LEFT = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic                         push,
  input  logic                         reset,
  input  logic                         D_in,
  output logic [WIDTH-1:0]             D_out
`ifdef MUX_DFF_FILL_CNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0]   fill_cnt,
  output logic                         full
`endif
);

  // Entry stage: LSB when shifting toward MSB, MSB when shifting toward LSB.
  localparam int ENTRY = SHIFT_LEFT ? 0 : WIDTH - 1;

  if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
    $error("serial_mux_dff_shift: WIDTH must be in 2..64");
  end

  logic [WIDTH-1:0] stage_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic nbr;

    // The entry cell has no upstream neighbour. Its unused mux leg is tied to
    // D_in so that every mux input is driven.
    if (i == ENTRY) begin : g_entry
      assign nbr = D_in;
    end else if (SHIFT_LEFT) begin : g_from_lower
      assign nbr = stage_q[i-1];
    end else begin : g_from_upper
      assign nbr = stage_q[i+1];
    end

    serial_mux_dff_cell #(
      .IS_ENTRY (i == ENTRY),
      .RST_BIT  (RESET_VAL[i])
    ) u_cell (
      .clk_i  (push),
      .rst_ni (reset),
      .ser_i  (D_in),
      .nbr_i  (nbr),
      .q_o    (stage_q[i])
    );
  end

  // D_out comes straight from the flops, so D_in has no combinational path to it.
  assign D_out = stage_q;

`ifdef MUX_DFF_FILL_CNT_EN
  localparam int                 CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Fill count next state: count each push and saturate once all stages are filled.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Fill count register: cleared together with the shift chain.
  always_ff @(posedge push or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fill_cnt = cnt_q;
  assign full     = (cnt_q == CNT_MAX);
`endif

endmodule

// File: tb/tb_serial_mux_dff_shift.sv
`timescale 1ns/1ps
module tb_serial_mux_dff_shift;

  logic       push;
  logic       reset;
  logic       D_in;
  logic [7:0] dout_l;
  logic [7:0] dout_r;
`ifdef MUX_DFF_FILL_CNT_EN
  logic [3:0] cnt_l, cnt_r;
  logic       full_l, full_r;
`endif

  int total = 0;
  int bad   = 0;

  serial_mux_dff_shift #(.WIDTH(8), .SHIFT_LEFT(1'b1), .RESET_VAL(8'h00)) dut_l (
    .push  (push),
    .reset (reset),
    .D_in  (D_in),
    .D_out (dout_l)
`ifdef MUX_DFF_FILL_CNT_EN
    ,
    .fill_cnt (cnt_l),
    .full     (full_l)
`endif
  );

  serial_mux_dff_shift #(.WIDTH(8), .SHIFT_LEFT(1'b0), .RESET_VAL(8'h00)) dut_r (
    .push  (push),
    .reset (reset),
    .D_in  (D_in),
    .D_out (dout_r)
`ifdef MUX_DFF_FILL_CNT_EN
    ,
    .fill_cnt (cnt_r),
    .full     (full_r)
`endif
  );

  // push: 10 ns period; rising edges at 5, 15, 25 ...; falling edges at 10, 20, ...
  initial push = 1'b0;
  always #5 push = ~push;

  task automatic test_reset();
    reset = 1'b0;
    D_in  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge push);
      total++;
      if (dout_l !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold_l edge%0d got=%h want=00", k, dout_l);
      end
      total++;
      if (dout_r !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold_r edge%0d got=%h want=00", k, dout_r);
      end
    end
  endtask

  task automatic test_fill_ones();
    logic [7:0] exp_l, exp_r;
    exp_l = 8'h00;
    exp_r = 8'h00;
    reset = 1'b1;  // released on a falling edge, clear of any rising edge
    D_in  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge push);
      exp_l = {exp_l[6:0], 1'b1};
      exp_r = {1'b1, exp_r[7:1]};
      total++;
      if (dout_l !== exp_l) begin
        bad++;
        $display("FAIL fill_ones_l edge%0d got=%h want=%h", k, dout_l, exp_l);
      end
      total++;
      if (dout_r !== exp_r) begin
        bad++;
        $display("FAIL fill_ones_r edge%0d got=%h want=%h", k, dout_r, exp_r);
      end
    end
  endtask

  task automatic test_async_reset();
    // Both registers hold FF here. Drop reset in the middle of push's high phase.
    @(posedge push);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (dout_l !== 8'h00) begin
      bad++;
      $display("FAIL async_reset_l got=%h want=00", dout_l);
    end
    total++;
    if (dout_r !== 8'h00) begin
      bad++;
      $display("FAIL async_reset_r got=%h want=00", dout_r);
    end
    @(negedge push);
    reset = 1'b1;
  endtask

  task automatic test_pattern();
    logic [7:0] bits;
    bits = 8'b1011_0010;  // bit 7 is shifted in first
    for (int k = 7; k >= 0; k--) begin
      D_in = bits[k];
      @(negedge push);
      if (k == 4) begin
        total++;
        if (dout_l !== 8'h0B) begin
          bad++;
          $display("FAIL pattern_half_l got=%h want=0b", dout_l);
        end
        total++;
        if (dout_r !== 8'hD0) begin
          bad++;
          $display("FAIL pattern_half_r got=%h want=d0", dout_r);
        end
      end
    end
    total++;
    if (dout_l !== 8'hB2) begin
      bad++;
      $display("FAIL pattern_l got=%h want=b2", dout_l);
    end
    total++;
    if (dout_r !== 8'h4D) begin
      bad++;
      $display("FAIL pattern_r got=%h want=4d", dout_r);
    end
  endtask

  task automatic test_reset_mid();
    D_in = 1'b1;
    repeat (9) @(negedge push);
    total++;
    if (dout_l !== 8'hFF) begin
      bad++;
      $display("FAIL mid_preload_l got=%h want=ff", dout_l);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (dout_l !== 8'h00) begin
      bad++;
      $display("FAIL mid_clear_l got=%h want=00", dout_l);
    end
    #14;          // reset low for 15 ns in total, spanning a rising edge
    reset = 1'b1; // released between a rising and a falling edge
    @(negedge push);
    total++;
    if (dout_l !== 8'h00) begin
      bad++;
      $display("FAIL mid_no_shift_l got=%h want=00", dout_l);
    end
    @(negedge push);
    total++;
    if (dout_l !== 8'h01) begin
      bad++;
      $display("FAIL mid_first_l got=%h want=01", dout_l);
    end
    total++;
    if (dout_r !== 8'h80) begin
      bad++;
      $display("FAIL mid_first_r got=%h want=80", dout_r);
    end
  endtask

  task automatic test_back_to_back();
    // Eight alternating bits, starting with 1, replace the whole word.
    for (int k = 0; k < 8; k++) begin
      D_in = (k % 2 == 0);
      @(negedge push);
    end
    total++;
    if (dout_l !== 8'hAA) begin
      bad++;
      $display("FAIL b2b_l got=%h want=aa", dout_l);
    end
    total++;
    if (dout_r !== 8'h55) begin
      bad++;
      $display("FAIL b2b_r got=%h want=55", dout_r);
    end
  endtask

`ifdef MUX_DFF_FILL_CNT_EN
  task automatic test_fill_cnt();
    logic [3:0] exp_c;
    @(negedge push);
    reset = 1'b0;
    #1;
    total++;
    if (cnt_l !== 4'd0 || full_l !== 1'b0) begin
      bad++;
      $display("FAIL cnt_reset got=%0d/%b want=0/0", cnt_l, full_l);
    end
    @(negedge push);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge push);
      exp_c = (k > 8) ? 4'd8 : 4'(k);
      total++;
      if (cnt_l !== exp_c || full_l !== (exp_c == 4'd8)) begin
        bad++;
        $display("FAIL cnt_step%0d got=%0d/%b want=%0d/%b", k, cnt_l, full_l, exp_c, exp_c == 4'd8);
      end
      total++;
      if (cnt_r !== exp_c || full_r !== (exp_c == 4'd8)) begin
        bad++;
        $display("FAIL cnt_r_step%0d got=%0d/%b want=%0d", k, cnt_r, full_r, exp_c);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (cnt_l !== 4'd0 || full_l !== 1'b0) begin
      bad++;
      $display("FAIL cnt_clear got=%0d/%b want=0/0", cnt_l, full_l);
    end
    @(negedge push);
    reset = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b0;
    D_in  = 1'b0;
    test_reset();
    test_fill_ones();
    test_async_reset();
    test_pattern();
    test_reset_mid();
    test_back_to_back();
`ifdef MUX_DFF_FILL_CNT_EN
    test_fill_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
